// File: rtl/counter_ctrl.sv
// Command-driven sequencer for the up-counter: start/pause/abort control,
// programmable prescaler and terminal value, one-shot or auto-reload.
module counter_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  abort,
    input  logic                  reload,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  paused,
    output logic                  done,
    output logic                  tc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t                  state_q,  state_d;
    logic [WIDTH-1:0]        count_q,  count_d;
    logic [PRESCALE_W-1:0]   pre_q,    pre_d;
    logic [WIDTH-1:0]        lim_q,    lim_d;
    logic [PRESCALE_W-1:0]   psc_q,    psc_d;
    logic                    rld_q,    rld_d;
    logic                    tc_q,     tc_d;

    // NOTE: every variable gets a hold default first so no path through the
    // case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        lim_d   = lim_q;
        psc_d   = psc_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            count_d = '0;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lim_d   = limit;
                        psc_d   = prescale;
                        rld_d   = reload;
                        count_d = '0;
                        pre_d   = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else if (pre_q != psc_q) begin
                        pre_d = pre_q + PRESCALE_W'(1);
                    end else begin
                        pre_d = '0;
                        if (count_q != lim_q) begin
                            count_d = count_q + WIDTH'(1);
                        end else begin
                            // Terminal step: wrap in reload mode, otherwise hold at the limit.
                            tc_d = 1'b1;
                            if (rld_q) begin
                                count_d = '0;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            pre_q   <= '0;
            lim_q   <= '0;
            psc_q   <= '0;
            rld_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            lim_q   <= lim_d;
            psc_q   <= psc_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    assign count  = count_q;
    assign busy   = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign paused = (state_q == S_PAUSED);
    assign done   = (state_q == S_DONE);
    assign tc     = tc_q;

endmodule
